// File: rtl/pipe_ctrl_if.sv
// Pipeline-control bundle: stall/redirect requests in, per-stage hold/flush vectors out.
// master = the controller, slave = the pipeline stages and pc that it drives.
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              stallreq_id_i;
    logic              stallreq_ex_i;
    logic              stallreq_bus_i;
    logic              jump_req_i;
    logic [31:0]       jump_addr_i;
    logic [4:0]        hold_en_o;
    logic [4:0]        flush_o;
    logic              jump_en_o;
    logic [31:0]       jump_addr_o;
    logic [1:0]        state_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        input  stallreq_id_i, stallreq_ex_i, stallreq_bus_i, jump_req_i, jump_addr_i,
        output hold_en_o, flush_o, jump_en_o, jump_addr_o, state_o, stall_cnt_o
    );

    modport slave (
        output stallreq_id_i, stallreq_ex_i, stallreq_bus_i, jump_req_i, jump_addr_i,
        input  hold_en_o, flush_o, jump_en_o, jump_addr_o, state_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Central 5-stage pipeline controller: prioritised stall/redirect decode, post-redirect
// fetch-shadow flush sequencing and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    pipe_ctrl_if.master     bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHADOW = 2'd1
    } state_t;

    state_t           state, state_n;
    logic [2:0]       fcnt, fcnt_n;
    logic [CNT_W-1:0] stall_cnt;

    logic [4:0]  hold;
    logic [4:0]  flush;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        jump_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage 0: combinational request decode, strict priority
    always_comb begin
        hold      = '0;
        flush     = '0;
        jump_en   = 1'b0;
        jump_addr = '0;
        jump_q    = 1'b0;
        if (bus.stallreq_ex_i) begin
            hold     = 5'b00111;
            flush[3] = 1'b1;
        end else if (bus.jump_req_i) begin
            jump_en   = 1'b1;
            jump_addr = bus.jump_addr_i;
            flush[1]  = 1'b1;
            flush[2]  = 1'b1;
            jump_q    = 1'b1;
        end else if (bus.stallreq_id_i) begin
            hold     = 5'b00011;
            flush[2] = 1'b1;
        end else if (bus.stallreq_bus_i) begin
            hold     = 5'b00001;
            flush[1] = 1'b1;
        end
        // Shadow flush wins over an if_id hold so the wrong-path fetch is still cleared
        if (state == SHADOW) flush[1] = 1'b1;
        if (rst) begin
            hold      = '0;
            flush     = '0;
            jump_en   = 1'b0;
            jump_addr = '0;
            jump_q    = 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        case (state)
            RUN: begin
                if (jump_q && FLUSH_CYCLES > 0) begin
                    state_n = SHADOW;
                    fcnt_n  = 3'(FLUSH_CYCLES);
                end
            end
            SHADOW: begin
                if (jump_q) begin
                    fcnt_n = 3'(FLUSH_CYCLES);
                end else if (!hold[0]) begin
                    fcnt_n = fcnt - 3'd1;
                    if (fcnt == 3'd1) state_n = RUN;
                end
            end
            default: begin
                state_n = RUN;
                fcnt_n  = '0;
            end
        endcase
    end

    // Stage 1: registered control state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            fcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
            if (|hold) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign bus.hold_en_o   = hold;
    assign bus.flush_o     = flush;
    assign bus.jump_en_o   = jump_en;
    assign bus.jump_addr_o = jump_addr;
    assign bus.state_o     = rst ? 2'd0 : state;
    assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: three instances (FLUSH_CYCLES=1, FLUSH_CYCLES=2, CNT_W=4)
// driven one at a time with directed vectors; a negedge monitor pops and compares.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(16)) if0 ();
    pipe_ctrl_if #(.CNT_W(16)) if1 ();
    pipe_ctrl_if #(.CNT_W(4))  if2 ();

    pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
    pipe_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
    pipe_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(if2.master));

    typedef struct {
        int          sel;
        int          tag;
        logic [4:0]  hold;
        logic [4:0]  flush;
        logic        jen;
        logic [31:0] addr;
        logic [1:0]  st;
        logic        chk_cnt;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int tag_n  = 0;

    task automatic set_in(input int sel, input logic ex, input logic jr, input logic id,
                          input logic bs, input logic [31:0] ja);
        if0.stallreq_ex_i = (sel == 0) & ex; if0.jump_req_i = (sel == 0) & jr;
        if0.stallreq_id_i = (sel == 0) & id; if0.stallreq_bus_i = (sel == 0) & bs;
        if0.jump_addr_i   = (sel == 0) ? ja : 32'h0;
        if1.stallreq_ex_i = (sel == 1) & ex; if1.jump_req_i = (sel == 1) & jr;
        if1.stallreq_id_i = (sel == 1) & id; if1.stallreq_bus_i = (sel == 1) & bs;
        if1.jump_addr_i   = (sel == 1) ? ja : 32'h0;
        if2.stallreq_ex_i = (sel == 2) & ex; if2.jump_req_i = (sel == 2) & jr;
        if2.stallreq_id_i = (sel == 2) & id; if2.stallreq_bus_i = (sel == 2) & bs;
        if2.jump_addr_i   = (sel == 2) ? ja : 32'h0;
    endtask

    task automatic step(input int sel, input logic r, input logic ex, input logic jr,
                        input logic id, input logic bs, input logic [31:0] ja,
                        input logic [4:0] eh, input logic [4:0] ef, input logic ej,
                        input logic [31:0] ea, input logic [1:0] es,
                        input logic cc, input logic [15:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        set_in(sel, ex, jr, id, bs, ja);
        e.sel = sel; e.tag = tag_n; e.hold = eh; e.flush = ef; e.jen = ej;
        e.addr = ea; e.st = es; e.chk_cnt = cc; e.cnt = ec;
        tag_n++;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0]  h, f;
            logic        j;
            logic [31:0] a;
            logic [1:0]  s;
            logic [15:0] c;
            e = exp_q.pop_front();
            case (e.sel)
                0: begin h = if0.hold_en_o; f = if0.flush_o; j = if0.jump_en_o;
                          a = if0.jump_addr_o; s = if0.state_o; c = if0.stall_cnt_o; end
                1: begin h = if1.hold_en_o; f = if1.flush_o; j = if1.jump_en_o;
                          a = if1.jump_addr_o; s = if1.state_o; c = if1.stall_cnt_o; end
                default: begin h = if2.hold_en_o; f = if2.flush_o; j = if2.jump_en_o;
                          a = if2.jump_addr_o; s = if2.state_o; c = {12'h0, if2.stall_cnt_o}; end
            endcase
            checks++;
            if (h !== e.hold || f !== e.flush || j !== e.jen || a !== e.addr || s !== e.st ||
                (e.chk_cnt && c !== e.cnt)) begin
                errors++;
                $display("FAIL step%0d dut%0d: got hold=%b flush=%b jen=%b addr=%h st=%0d cnt=%0d; want hold=%b flush=%b jen=%b addr=%h st=%0d cnt=%0d(chk=%0d)",
                         e.tag, e.sel, h, f, j, a, s, c,
                         e.hold, e.flush, e.jen, e.addr, e.st, e.cnt, e.chk_cnt);
            end
        end
    end

    initial begin
        set_in(0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0040);
        // Reset held for two edges with ex stall and jump asserted: everything quiet
        step(0, 1, 1, 1, 0, 0, 32'h40, 5'b00000, 5'b00000, 0, 32'h0, 2'd0, 1, 16'd0);
        step(0, 1, 1, 1, 0, 0, 32'h40, 5'b00000, 5'b00000, 0, 32'h0, 2'd0, 1, 16'd0);
        step(0, 0, 1, 0, 0, 0, 32'h0,  5'b00111, 5'b01000, 0, 32'h0, 2'd0, 1, 16'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0,  5'b00000, 5'b00000, 0, 32'h0, 2'd0, 1, 16'd1);
        // Jump with FLUSH_CYCLES=1
        step(0, 0, 0, 1, 0, 0, 32'h100, 5'b00000, 5'b00110, 1, 32'h100, 2'd0, 1, 16'd1);
        step(0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00010, 0, 32'h0,   2'd1, 0, 16'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00000, 0, 32'h0,   2'd0, 0, 16'd0);
        // Priority: ex beats jump beats id
        step(0, 0, 1, 1, 1, 0, 32'hDEAD, 5'b00111, 5'b01000, 0, 32'h0, 2'd0, 1, 16'd1);
        // Load-use then bus wait
        step(0, 0, 0, 0, 1, 0, 32'h0, 5'b00011, 5'b00100, 0, 32'h0, 2'd0, 1, 16'd2);
        step(0, 0, 0, 0, 0, 1, 32'h0, 5'b00001, 5'b00010, 0, 32'h0, 2'd0, 1, 16'd3);
        step(0, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 5'b00000, 0, 32'h0, 2'd0, 1, 16'd4);
        // Jump masks a simultaneous id/bus request
        step(0, 0, 0, 1, 1, 1, 32'h180, 5'b00000, 5'b00110, 1, 32'h180, 2'd0, 1, 16'd4);
        step(0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00010, 0, 32'h0,   2'd1, 1, 16'd4);
        // Ex stall inside the shadow: if_id held and flushed, shadow extended
        step(0, 0, 0, 1, 0, 0, 32'h200, 5'b00000, 5'b00110, 1, 32'h200, 2'd0, 0, 16'd0);
        step(0, 0, 1, 0, 0, 0, 32'h0,   5'b00111, 5'b01010, 0, 32'h0,   2'd1, 0, 16'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00010, 0, 32'h0,   2'd1, 0, 16'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00000, 0, 32'h0,   2'd0, 0, 16'd0);
        // FLUSH_CYCLES=2: bus stall freezes the count, back-to-back jump reloads it
        step(1, 0, 0, 1, 0, 0, 32'h300, 5'b00000, 5'b00110, 1, 32'h300, 2'd0, 0, 16'd0);
        step(1, 0, 0, 0, 0, 1, 32'h0,   5'b00001, 5'b00010, 0, 32'h0,   2'd1, 0, 16'd0);
        step(1, 0, 0, 1, 0, 0, 32'h400, 5'b00000, 5'b00110, 1, 32'h400, 2'd1, 0, 16'd0);
        step(1, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00010, 0, 32'h0,   2'd1, 0, 16'd0);
        step(1, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00010, 0, 32'h0,   2'd1, 0, 16'd0);
        step(1, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00000, 0, 32'h0,   2'd0, 1, 16'd1);
        // CNT_W=4 saturation
        for (int k = 0; k < 20; k++)
            step(2, 0, 0, 0, 0, 1, 32'h0, 5'b00001, 5'b00010, 0, 32'h0, 2'd0, 1,
                 (k > 15) ? 16'd15 : 16'(k));
        step(2, 0, 0, 0, 0, 0, 32'h0, 5'b00000, 5'b00000, 0, 32'h0, 2'd0, 1, 16'd15);
        // Reset in the middle of a shadow aborts it
        step(0, 0, 0, 1, 0, 0, 32'h500, 5'b00000, 5'b00110, 1, 32'h500, 2'd0, 0, 16'd0);
        step(0, 1, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00000, 0, 32'h0,   2'd0, 0, 16'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00000, 0, 32'h0,   2'd0, 1, 16'd0);
        step(0, 0, 0, 0, 0, 0, 32'h0,   5'b00000, 5'b00000, 0, 32'h0,   2'd0, 1, 16'd0);
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
